// File: rtl/block_xfer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : block_xfer_seq_pkg
// Description : Shared definitions for the block transfer sequencer: bus width
//               defaults, word step and the FSM state encoding.
//               Optional feature macro: BLOCK_XFER_WB_EN (base writeback).
// Revision    : 1.0 - initial release
// ============================================================================
package block_xfer_seq_pkg;

    localparam int ADDRLEN_DEF = 4;
    localparam int DBUSLEN_DEF = 32;
    localparam int WORD_STEP   = 4;
    localparam int LIST_W      = 16;

`ifdef BLOCK_XFER_WB_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FIN  = 2'd2,
        ST_WB   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FIN  = 2'd2
    } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/block_xfer_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : block_xfer_seq_if
// Description : Command, memory and register-file signals of the block
//               transfer sequencer. The slave modport is the sequencer side,
//               the master modport is the controller/environment side.
//               Optional feature macro: BLOCK_XFER_WB_EN (base writeback).
// Revision    : 1.0 - initial release
// ============================================================================
interface block_xfer_seq_if
    import block_xfer_seq_pkg::*;
#(
    parameter int ADDRLEN = ADDRLEN_DEF,
    parameter int DBUSLEN = DBUSLEN_DEF
);
    logic               start;
    logic               is_load;
    logic               up;
    logic               pre;
    logic               writeback;
    logic [ADDRLEN-1:0] base_reg;
    logic [15:0]        reg_list;
    logic [DBUSLEN-1:0] base_val;
    logic               mem_req;
    logic               mem_we;
    logic [DBUSLEN-1:0] mem_addr;
    logic               mem_ack;
    logic [DBUSLEN-1:0] mem_rdata;
    logic [DBUSLEN-1:0] RF_Bus_C;
    logic [DBUSLEN-1:0] mem_wdata;
    logic [ADDRLEN-1:0] RF_Addr_C;
    logic [ADDRLEN-1:0] RF_Addr_Write;
    logic [DBUSLEN-1:0] RF_Bus_Write;
    logic               RF_Load_Write;
    logic               busy;
    logic               done;

    modport slave (
        input  start, is_load, up, pre, writeback, base_reg, reg_list, base_val,
        input  mem_ack, mem_rdata, RF_Bus_C,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output RF_Addr_C, RF_Addr_Write, RF_Bus_Write, RF_Load_Write,
        output busy, done
    );

    modport master (
        output start, is_load, up, pre, writeback, base_reg, reg_list, base_val,
        output mem_ack, mem_rdata, RF_Bus_C,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  RF_Addr_C, RF_Addr_Write, RF_Bus_Write, RF_Load_Write,
        input  busy, done
    );

endinterface
`default_nettype wire

// File: rtl/block_xfer_seq_penc.sv
`default_nettype none
// ============================================================================
// Module      : reg_list_penc
// Description : Lowest-set-bit index, non-empty flag and population count of
//               a 16-bit register list.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_list_penc (
    input  logic [15:0] i_list,
    output logic [3:0]  o_idx,
    output logic        o_valid,
    output logic [4:0]  o_count
);

    // Scan downward so the last hit written is the lowest set bit.
    always_comb begin
        o_idx   = 4'd0;
        o_count = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (i_list[i]) begin
                o_idx = 4'(i);
            end
        end
        for (int i = 0; i < 16; i++) begin
            o_count = o_count + 5'(i_list[i]);
        end
        o_valid = |i_list;
    end

endmodule
`default_nettype wire

// File: rtl/block_xfer_seq.sv
`default_nettype none
// ============================================================================
// Module      : block_xfer_seq
// Description : LDM/STM block transfer sequencer. Walks the register list in
//               ascending order, one memory beat per register, with optional
//               base-register writeback.
//               Optional feature macro: BLOCK_XFER_WB_EN (base writeback).
// Revision    : 1.0 - initial release
// ============================================================================
module block_xfer_seq
    import block_xfer_seq_pkg::*;
#(
    parameter int ADDRLEN = ADDRLEN_DEF,
    parameter int DBUSLEN = DBUSLEN_DEF
) (
    input  logic             sysclk,
    input  logic             reset,
    block_xfer_seq_if.slave  bus
);

    localparam logic [DBUSLEN-1:0] C_STEP = DBUSLEN'(WORD_STEP);

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_list;
    logic               r_load;
    logic [DBUSLEN-1:0] r_addr;
    logic [15:0]        w_penc_in;
    logic [3:0]         w_idx;
    logic               w_valid;
    logic [4:0]         w_count;
    logic [DBUSLEN-1:0] w_span;
    logic [DBUSLEN-1:0] w_start_addr;
    logic               w_beat_done;
    logic               w_last_beat;
`ifdef BLOCK_XFER_WB_EN
    logic               r_wb_do;
    logic [ADDRLEN-1:0] r_base_reg;
    logic [DBUSLEN-1:0] r_wb_val;
`endif

    // In IDLE the encoder counts the incoming list; afterwards it walks the
    // working copy, so a single instance serves both purposes.
    assign w_penc_in = (r_state == ST_IDLE) ? bus.reg_list : r_list;

    reg_list_penc u_penc (
        .i_list  (w_penc_in),
        .o_idx   (w_idx),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign w_beat_done = (r_state == ST_XFER) && w_valid && bus.mem_ack;
    assign w_last_beat = w_beat_done && (w_count == 5'd1);
    assign bus.mem_wdata = bus.RF_Bus_C;

    // Start address: lowest register always lands on the lowest address.
    always_comb begin
        w_span = DBUSLEN'(w_count) * C_STEP;
        unique case ({bus.up, bus.pre})
            2'b10:   w_start_addr = bus.base_val;
            2'b11:   w_start_addr = bus.base_val + C_STEP;
            2'b00:   w_start_addr = bus.base_val - w_span + C_STEP;
            default: w_start_addr = bus.base_val - w_span;
        endcase
    end

    // State register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Command latch on accepted start; list/address advance per completed beat.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_list     <= 16'd0;
            r_load     <= 1'b0;
            r_addr     <= '0;
`ifdef BLOCK_XFER_WB_EN
            r_wb_do    <= 1'b0;
            r_base_reg <= '0;
            r_wb_val   <= '0;
`endif
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_list     <= bus.reg_list;
            r_load     <= bus.is_load;
            r_addr     <= w_start_addr;
`ifdef BLOCK_XFER_WB_EN
            // A loaded base register keeps the loaded value.
            r_wb_do    <= bus.writeback && !(bus.is_load && bus.reg_list[bus.base_reg]);
            r_base_reg <= bus.base_reg;
            r_wb_val   <= bus.up ? (bus.base_val + w_span) : (bus.base_val - w_span);
`endif
        end else if (w_beat_done) begin
            r_list <= r_list & ~(16'd1 << w_idx);
            r_addr <= r_addr + C_STEP;
        end
    end

    // Next-state and output decode; everything idles at zero.
    always_comb begin
        w_next            = r_state;
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_addr      = '0;
        bus.RF_Addr_C     = '0;
        bus.RF_Addr_Write = '0;
        bus.RF_Bus_Write  = '0;
        bus.RF_Load_Write = 1'b0;
        bus.busy          = (r_state != ST_IDLE);
        bus.done          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!w_valid) begin
                    w_next = ST_FIN;
                end else begin
                    bus.mem_req   = 1'b1;
                    bus.mem_we    = ~r_load;
                    bus.mem_addr  = r_addr;
                    bus.RF_Addr_C = ADDRLEN'(w_idx);
                    if (r_load && bus.mem_ack) begin
                        bus.RF_Load_Write = 1'b1;
                        bus.RF_Addr_Write = ADDRLEN'(w_idx);
                        bus.RF_Bus_Write  = bus.mem_rdata;
                    end
                    if (w_last_beat) begin
`ifdef BLOCK_XFER_WB_EN
                        w_next = r_wb_do ? ST_WB : ST_FIN;
`else
                        w_next = ST_FIN;
`endif
                    end
                end
            end
`ifdef BLOCK_XFER_WB_EN
            ST_WB: begin
                bus.RF_Load_Write = 1'b1;
                bus.RF_Addr_Write = r_base_reg;
                bus.RF_Bus_Write  = r_wb_val;
                w_next            = ST_FIN;
            end
`endif
            ST_FIN: begin
                bus.done = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_block_xfer_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_xfer_seq
// Description : Directed self-checking bench for block_xfer_seq.
//               Optional feature macro: BLOCK_XFER_WB_EN (base writeback).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_xfer_seq;

    localparam int AL = 4;
    localparam int DL = 32;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 sysclk = ~sysclk;

    block_xfer_seq_if #(.ADDRLEN(AL), .DBUSLEN(DL)) bus_if ();

    block_xfer_seq #(.ADDRLEN(AL), .DBUSLEN(DL)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic cmd(input logic ld, input logic u, input logic p, input logic wb,
                       input logic [AL-1:0] br, input logic [15:0] list,
                       input logic [DL-1:0] base);
        bus_if.start     = 1'b1;
        bus_if.is_load   = ld;
        bus_if.up        = u;
        bus_if.pre       = p;
        bus_if.writeback = wb;
        bus_if.base_reg  = br;
        bus_if.reg_list  = list;
        bus_if.base_val  = base;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 32'h0);
        bus_if.start     = 1'b0;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 32'h0;
        bus_if.RF_Bus_C  = 32'h0;
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_done", bus_if.done, 0);
        chk("rst_req", bus_if.mem_req, 0);
        chk("rst_we", bus_if.mem_we, 0);
        chk("rst_lw", bus_if.RF_Load_Write, 0);
        chk("rst_addr", bus_if.mem_addr, 0);
        chk("rst_rfc", bus_if.RF_Addr_C, 0);
        chk("rst_aw", bus_if.RF_Addr_Write, 0);
        chk("rst_bw", bus_if.RF_Bus_Write, 0);
        reset = 1'b0;
        cyc();

        // STM IA, base 0x100, R0..R3, ack every cycle
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h000F, 32'h100);
        bus_if.mem_ack = 1'b1;
        #1;
        chk("t1_idle_busy", bus_if.busy, 0);
        cyc();
        bus_if.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_if.RF_Bus_C = 32'hCAFE_0000 + k;
            #1;
            chk("t1_req", bus_if.mem_req, 1);
            chk("t1_we", bus_if.mem_we, 1);
            chk("t1_addr", bus_if.mem_addr, 32'h100 + 4 * k);
            chk("t1_rfc", bus_if.RF_Addr_C, k);
            chk("t1_wdata", bus_if.mem_wdata, 32'hCAFE_0000 + k);
            chk("t1_done_early", bus_if.done, 0);
            cyc();
        end
        chk("t1_done", bus_if.done, 1);
        chk("t1_fin_busy", bus_if.busy, 1);
        chk("t1_fin_req", bus_if.mem_req, 0);
        cyc();
        chk("t1_done_clr", bus_if.done, 0);
        chk("t1_idle", bus_if.busy, 0);

        // LDM DB with writeback, base R13 = 0x200, list R0,R15 (back-to-back start)
        cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 16'h8001, 32'h200);
        bus_if.mem_rdata = 32'h1111_1111;
        #1;
        cyc();
        bus_if.start = 1'b0;
        #1;
        chk("t2_addr0", bus_if.mem_addr, 32'h1F8);
        chk("t2_rfc0", bus_if.RF_Addr_C, 0);
        chk("t2_we0", bus_if.mem_we, 0);
        chk("t2_lw0", bus_if.RF_Load_Write, 1);
        chk("t2_aw0", bus_if.RF_Addr_Write, 0);
        chk("t2_bw0", bus_if.RF_Bus_Write, 32'h1111_1111);
        cyc();
        bus_if.mem_rdata = 32'h2222_2222;
        #1;
        chk("t2_addr1", bus_if.mem_addr, 32'h1FC);
        chk("t2_rfc1", bus_if.RF_Addr_C, 15);
        chk("t2_lw1", bus_if.RF_Load_Write, 1);
        chk("t2_aw1", bus_if.RF_Addr_Write, 15);
        chk("t2_bw1", bus_if.RF_Bus_Write, 32'h2222_2222);
        cyc();
`ifdef BLOCK_XFER_WB_EN
        chk("t2_wb_lw", bus_if.RF_Load_Write, 1);
        chk("t2_wb_aw", bus_if.RF_Addr_Write, 13);
        chk("t2_wb_bw", bus_if.RF_Bus_Write, 32'h1F8);
        chk("t2_wb_done", bus_if.done, 0);
        chk("t2_wb_req", bus_if.mem_req, 0);
        cyc();
`endif
        chk("t2_done", bus_if.done, 1);
        chk("t2_fin_lw", bus_if.RF_Load_Write, 0);
        cyc();
        chk("t2_idle", bus_if.busy, 0);

        // LDM IA with writeback, base R2 is in the list: loaded value wins
        cmd(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0004, 32'h300);
        bus_if.mem_rdata = 32'h3333_3333;
        #1;
        cyc();
        bus_if.start = 1'b0;
        #1;
        chk("t3_addr", bus_if.mem_addr, 32'h300);
        chk("t3_rfc", bus_if.RF_Addr_C, 2);
        chk("t3_lw", bus_if.RF_Load_Write, 1);
        chk("t3_aw", bus_if.RF_Addr_Write, 2);
        chk("t3_bw", bus_if.RF_Bus_Write, 32'h3333_3333);
        cyc();
        chk("t3_done", bus_if.done, 1);
        chk("t3_no_wb", bus_if.RF_Load_Write, 0);
        cyc();
        chk("t3_idle", bus_if.busy, 0);

        // STM IB, base 0x400, R0..R2, 3-cycle stall on beat 2, start held while busy
        cmd(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0007, 32'h400);
        bus_if.mem_ack = 1'b1;
        #1;
        cyc();
        bus_if.start = 1'b0;
        #1;
        chk("t4_addr0", bus_if.mem_addr, 32'h404);
        chk("t4_rfc0", bus_if.RF_Addr_C, 0);
        cyc();
        bus_if.mem_ack  = 1'b0;
        bus_if.start    = 1'b1;
        bus_if.base_val = 32'hDEAD_0000;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("t4_stall_req", bus_if.mem_req, 1);
            chk("t4_stall_addr", bus_if.mem_addr, 32'h408);
            chk("t4_stall_rfc", bus_if.RF_Addr_C, 1);
            chk("t4_stall_done", bus_if.done, 0);
            cyc();
        end
        bus_if.start   = 1'b0;
        bus_if.mem_ack = 1'b1;
        #1;
        chk("t4_addr1", bus_if.mem_addr, 32'h408);
        cyc();
        chk("t4_addr2", bus_if.mem_addr, 32'h40C);
        chk("t4_rfc2", bus_if.RF_Addr_C, 2);
        cyc();
        chk("t4_done", bus_if.done, 1);
        cyc();
        chk("t4_idle", bus_if.busy, 0);

        // Empty list: no memory traffic, done two cycles after start
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 32'h500);
        #1;
        cyc();
        bus_if.start = 1'b0;
        #1;
        chk("t5_req", bus_if.mem_req, 0);
        chk("t5_busy", bus_if.busy, 1);
        chk("t5_done_early", bus_if.done, 0);
        cyc();
        chk("t5_done", bus_if.done, 1);
        cyc();
        chk("t5_idle", bus_if.busy, 0);

        // LDM DA, base 0x500, R4..R7, reset during the second beat
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h00F0, 32'h500);
        bus_if.mem_ack = 1'b0;
        #1;
        cyc();
        bus_if.start = 1'b0;
        #1;
        chk("t6_addr0", bus_if.mem_addr, 32'h4F4);
        chk("t6_rfc0", bus_if.RF_Addr_C, 4);
        chk("t6_lw_stall", bus_if.RF_Load_Write, 0);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 32'h4444_4444;
        #1;
        chk("t6_lw0", bus_if.RF_Load_Write, 1);
        chk("t6_aw0", bus_if.RF_Addr_Write, 4);
        cyc();
        chk("t6_addr1", bus_if.mem_addr, 32'h4F8);
        chk("t6_rfc1", bus_if.RF_Addr_C, 5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("t6_rst_busy", bus_if.busy, 0);
        chk("t6_rst_req", bus_if.mem_req, 0);
        chk("t6_rst_lw", bus_if.RF_Load_Write, 0);
        chk("t6_rst_addr", bus_if.mem_addr, 0);
        chk("t6_rst_rfc", bus_if.RF_Addr_C, 0);
        chk("t6_rst_aw", bus_if.RF_Addr_Write, 0);
        chk("t6_rst_bw", bus_if.RF_Bus_Write, 0);
        chk("t6_rst_done", bus_if.done, 0);
        cyc();
        chk("t6_no_resume_busy", bus_if.busy, 0);
        chk("t6_no_resume_lw", bus_if.RF_Load_Write, 0);
        chk("t6_no_resume_req", bus_if.mem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_xfer_seq.md
BLOCK_XFER_SEQ -- requirements
Module: block_xfer_seq

Interface
REQ-001 Parameter ADDRLEN, default 4, register-address width.
REQ-002 Parameter DBUSLEN, default 32, data/address bus width.
REQ-003 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-004 Port sysclk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: begin a transfer; sampled only in IDLE.
REQ-007 Port is_load, input, 1 bit: 1 = LDM, 0 = STM.
REQ-008 Port up / pre / writeback, inputs, 1 bit each: increment, before-mode, base writeback request.
REQ-009 Port base_reg, input, ADDRLEN bits: base register number.
REQ-010 Port reg_list, input, 16 bits: register list; bit i selects Ri.
REQ-011 Port base_val, input, DBUSLEN bits: base value, sampled with start.
REQ-012 Port mem_req / mem_we, outputs, 1 bit each: memory request and write strobe.
REQ-013 Port mem_addr, output, DBUSLEN bits: word address.
REQ-014 Port mem_ack, input, 1 bit: request completes this cycle.
REQ-015 Port mem_rdata, input, DBUSLEN bits: load data, valid with mem_ack.
REQ-016 Port RF_Bus_C, input, DBUSLEN bits: store data, read from register file port C.
REQ-017 Port mem_wdata, output, DBUSLEN bits: equals RF_Bus_C.
REQ-018 Ports RF_Addr_C / RF_Addr_Write, outputs, ADDRLEN bits each: register-file read-C and write addresses.
REQ-019 Port RF_Bus_Write, output, DBUSLEN bits: register-file write data.
REQ-020 Port RF_Load_Write, output, 1 bit: register-file write enable.
REQ-021 Ports busy / done, outputs, 1 bit each: busy indicator; done is a one-cycle completion pulse.

Function
REQ-022 The FSM SHALL have states IDLE, XFER, WB and FIN.
REQ-023 On start in IDLE, the block SHALL latch all inputs, set n = popcount(reg_list) and enter XFER; the following cycle it SHALL enter FIN if n = 0.
REQ-024 The start address SHALL be: IA base; IB base+4; DA base-4n+4; DB base-4n, all modulo 2^DBUSLEN.
REQ-025 Registers SHALL transfer in ascending number order, lowest register at lowest address, with the address advancing +4 per completed beat.
REQ-026 In XFER, mem_req SHALL be 1, mem_we = ~is_load, and RF_Addr_C = the current register.
REQ-027 A beat SHALL complete only on mem_ack; mem_req SHALL stay high, with address and data held, across stalls.
REQ-028 On a load beat with mem_ack, RF_Load_Write SHALL be 1 for exactly that cycle, with RF_Addr_Write = the current register and RF_Bus_Write = mem_rdata.
REQ-029 After the last ack, the FSM SHALL go to WB if writeback is active, otherwise to FIN.
REQ-030 WB SHALL last one cycle and write base_reg with base ±4n.
REQ-031 Writeback SHALL be suppressed when is_load=1 and reg_list[base_reg]=1, so the loaded value wins.
REQ-032 FIN SHALL pulse done for one cycle, then the FSM SHALL return to IDLE; busy SHALL be 1 in all states except IDLE.
REQ-033 start while busy SHALL be ignored.
REQ-034 Back-to-back operation SHALL be allowed: a start in the IDLE cycle directly after FIN is accepted.

Reset
REQ-035 Reset SHALL take priority over all other inputs and force IDLE at the next edge, including mid-transfer; an aborted transfer SHALL not be resumed.
REQ-036 After reset, busy, done, mem_req, mem_we and RF_Load_Write SHALL be 0, and mem_addr, RF_Addr_C, RF_Addr_Write and RF_Bus_Write SHALL be 0.

Configuration
REQ-037 Macro BLOCK_XFER_WB_EN SHALL select base writeback.
REQ-038 With BLOCK_XFER_WB_EN defined, WB SHALL behave per REQ-029 to REQ-031.
REQ-039 Without BLOCK_XFER_WB_EN, the writeback input SHALL be ignored, the WB state SHALL be absent, and XFER SHALL go directly to FIN.

Structure
REQ-040 The shared package SHALL hold the FSM state enum, ADDRLEN/DBUSLEN defaults, and the word-step constant 4.
REQ-041 Sub-module reg_list_penc SHALL provide lowest-set-bit index, valid flag and popcount for a 16-bit list.
REQ-042 The served bit SHALL be cleared from a working copy of the list after each beat.

Verification
REQ-043 STM IA, base=0x100, list=0x000F, ack every cycle -> addresses 0x100, 0x104, 0x108, 0x10C; RF_Addr_C 0..3; done 5 cycles after start.
REQ-044 LDM DB with writeback, base R13=0x200, list=0x8001 -> reads 0x1F8 (R0) and 0x1FC (R15); WB writes R13=0x1F8.
REQ-045 LDM IA with writeback, base R2, list=0x0004 -> R2 = mem_rdata; no WB write occurs.
REQ-046 list=0x0000 -> no mem_req; done 2 cycles after start.
REQ-047 mem_ack held low 3 cycles on beat 2 -> mem_addr and mem_req stable; total latency +3.
REQ-048 reset asserted mid-XFER -> next cycle IDLE, all outputs 0, no further RF writes.
